// File: rtl/l2_pkg.sv
// l2_pkg: shared widths, iteration count, FIFO depth and FSM states for l2_sqrt
package l2_pkg;
  localparam int F_W        = 20;
  localparam int NORM_W     = 10;
  localparam int SQRT_ITERS = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int REM_W      = NORM_W + 3;
  localparam int ITER_W     = $clog2(SQRT_ITERS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int ENTRY_W    = F_W + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/l2_sqrt_fifo.sv
// l2_sqrt_fifo: 4-entry FIFO of {ovf, f} that accepts a push on a full cycle if a pop frees a slot
module l2_sqrt_fifo
  import l2_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               wr, rd;
  assign full  = count_q == CNT_W'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem_q[rd_q];
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  // pointer, occupancy and storage next-state
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_q] = din;
    wr_d    = wr ? wr_q + 1'b1 : wr_q;
    rd_d    = rd ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CNT_W'(wr) - CNT_W'(rd);
  end
  // control state with reset; storage contents need none
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  // storage array
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/l2_sqrt.sv
// l2_sqrt: queued floor(sqrt(f)) using a restoring one-bit-per-cycle square root
module l2_sqrt
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [F_W-1:0]    f,
  input  logic              ovf_in,
  output logic [NORM_W-1:0] norm,
  output logic              valid_out,
  output logic              overflow,
  output logic              busy,
  output logic              drop
);
  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]   fifo_count;
  state_e             state_q, state_d;
  logic [F_W-1:0]     rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d, rem_sh, trial;
  logic [NORM_W-1:0]  root_q, root_d, norm_q, norm_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               ovf_q, ovf_d, valid_q, valid_d, overflow_q, overflow_d, drop_q, drop_d, ge;
  l2_sqrt_fifo u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (valid_in),
    .pop   (pop),
    .din   ({ovf_in, f}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  assign pop       = state_q == IDLE && !fifo_empty;
  assign busy      = fifo_count != '0 || state_q != IDLE;
  assign rem_sh    = {rem_q[REM_W-3:0], rad_q[F_W-1 -: 2]};
  assign trial     = {1'b0, root_q, 2'b01};
  assign ge        = rem_sh >= trial;
  assign norm      = norm_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_q;
  assign drop      = drop_q;
  // FSM next-state plus square-root datapath and result registers
  always_comb begin
    state_d    = state_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    ovf_d      = ovf_q;
    norm_d     = norm_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    drop_d     = drop_q | (valid_in & fifo_full & ~pop);
    case (state_q)
      IDLE: if (pop) begin
        rad_d   = fifo_dout[F_W-1:0];
        ovf_d   = fifo_dout[F_W];
        rem_d   = '0;
        root_d  = '0;
        iter_d  = '0;
        state_d = CALC;
      end
      CALC: begin
        rem_d   = ge ? rem_sh - trial : rem_sh;
        root_d  = {root_q[NORM_W-2:0], ge};
        rad_d   = {rad_q[F_W-3:0], 2'b00};
        iter_d  = iter_q + 1'b1;
        state_d = iter_q == ITER_W'(SQRT_ITERS - 1) ? DONE : CALC;
      end
      DONE: begin
        norm_d     = ovf_q ? '1 : root_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset abandons any in-flight result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      ovf_q      <= 1'b0;
      norm_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      ovf_q      <= ovf_d;
      norm_q     <= norm_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_l2_sqrt.sv
// tb_l2_sqrt: table-driven and scoreboarded checks of l2_sqrt results, latency, drop and reset
module tb_l2_sqrt;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [19:0] f = '0;
  logic        ovf_in = 1'b0;
  logic [9:0]  norm;
  logic        valid_out, overflow, busy, drop;
  int          cyc = 0;
  int          applied = 0;
  int          miscmp = 0;
  typedef struct {logic [9:0] norm; logic ovf; int t;} exp_t;
  typedef struct {logic [19:0] f; logic ovf; logic [9:0] norm; logic eovf;} vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[8];

  l2_sqrt dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .f         (f),
    .ovf_in    (ovf_in),
    .norm      (norm),
    .valid_out (valid_out),
    .overflow  (overflow),
    .busy      (busy),
    .drop      (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (sb.size() == 0) begin
        applied++;
        miscmp++;
        $display("FAIL unexpected_valid: got valid_out=1 norm=%0d expected no result (cycle %0d)", norm, cyc);
      end else begin
        e = sb.pop_front();
        chk("norm", norm, e.norm);
        chk("overflow", overflow, e.ovf);
        chk("latency", cyc, e.t);
      end
    end
  end

  // called at a negedge; the sample is taken on the next posedge
  task automatic send(logic [19:0] fv, logic ov);
    valid_in = 1'b1;
    f = fv;
    ovf_in = ov;
    @(negedge clk);
    valid_in = 1'b0;
    ovf_in = 1'b0;
  endtask

  task automatic expect_res(logic [9:0] n, logic ov, int t);
    exp_t x;
    x.norm = n;
    x.ovf = ov;
    x.t = t;
    sb.push_back(x);
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", int'(n < bound), 1);
  endtask

  initial begin
    tbl[0] = '{20'd0,       1'b0, 10'd0,    1'b0};
    tbl[1] = '{20'd1,       1'b0, 10'd1,    1'b0};
    tbl[2] = '{20'd143,     1'b0, 10'd11,   1'b0};
    tbl[3] = '{20'd144,     1'b0, 10'd12,   1'b0};
    tbl[4] = '{20'd1048575, 1'b0, 10'd1023, 1'b0};
    tbl[5] = '{20'd1046529, 1'b0, 10'd1023, 1'b0};
    tbl[6] = '{20'd1046528, 1'b0, 10'd1022, 1'b0};
    tbl[7] = '{20'd500,     1'b1, 10'h3FF,  1'b1};

    valid_in = 1'b1;
    f = 20'd9;
    repeat (2) @(negedge clk);
    chk("rst_norm", norm, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    chk("rst_valid_in_ignored", busy, 0);

    for (int i = 0; i < 8; i++) begin
      expect_res(tbl[i].norm, tbl[i].eovf, cyc + 13);
      send(tbl[i].f, tbl[i].ovf);
      drain(40);
    end
    repeat (3) @(negedge clk);
    chk("norm_hold", norm, 10'h3FF);
    chk("overflow_hold", overflow, 1);

    begin
      logic [19:0] bf[6];
      int c0;
      bf = '{20'd16, 20'd25, 20'd36, 20'd49, 20'd64, 20'd81};
      c0 = cyc + 1;
      for (int k = 0; k < 6; k++) begin
        if (k < 5) expect_res(10'(k + 4), 1'b0, c0 + 12 * (k + 1));
        chk("drop_before_full", drop, 0);
        send(bf[k], 1'b0);
      end
      chk("drop_set", drop, 1);
      drain(100);
      chk("burst_busy_end", busy, 0);
      chk("drop_sticky", drop, 1);
    end

    begin
      int seen = 0;
      for (int k = 0; k < 3; k++) send(20'd400 + 20'(k), 1'b0);
      repeat (4) @(negedge clk);
      chk("busy_in_calc", busy, 1);
      reset = 1'b1;
      valid_in = 1'b1;
      f = 20'd77;
      @(negedge clk);
      reset = 1'b0;
      valid_in = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (valid_out) seen++;
      end
      chk("no_valid_after_reset", seen, 0);
      chk("post_rst_norm", norm, 0);
      chk("post_rst_drop", drop, 0);
      chk("post_rst_busy", busy, 0);
    end

    for (int i = 0; i < 20; i++) begin
      logic [19:0] rv;
      rv = 20'($urandom_range(0, 1048575));
      if (i == 0) rv = 20'd1048575;
      expect_res(10'(isqrt(int'(rv))), 1'b0, cyc + 13);
      send(rv, 1'b0);
      repeat ($urandom_range(11, 18)) @(negedge clk);
    end
    drain(60);
    chk("random_drop_clear", drop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end
endmodule

// File: doc/l2_sqrt.md
L2_SQRT -- requirements
Module: l2_sqrt

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
  clk        in   1   clock, all state on rising edge
  reset      in   1   synchronous active-high reset
  valid_in   in   1   f/ovf_in carry a sum-of-squares this cycle
  f          in   20  unsigned sum of squares from the accumulator stage
  ovf_in     in   1   accumulator overflow flag, qualified by valid_in
  norm       out  10  floor(sqrt(f)), registered
  valid_out  out  1   norm/overflow valid, one-cycle pulse per result
  overflow   out  1   result saturated because ovf_in was set
  busy       out  1   FIFO non-empty or FSM not IDLE
  drop       out  1   sticky: at least one input was lost because the FIFO was full

Function
REQ-003 An input SHALL be pushed into a 4-entry FIFO of {f, ovf_in} on every rising edge where valid_in=1 and the FIFO is not full or is popped in the same cycle.
REQ-004 valid_in=1 with the FIFO full and no pop that cycle SHALL discard the sample and set drop=1 until reset.
REQ-005 The FSM SHALL have states IDLE, CALC, DONE.
REQ-006 IDLE with FIFO non-empty SHALL pop the head entry, load the radicand and go to CALC; otherwise it SHALL remain in IDLE.
REQ-007 CALC SHALL perform restoring digit-by-digit square root, one result bit per cycle, MSB first, for exactly 10 cycles, then go to DONE.
REQ-008 DONE SHALL register norm and overflow, pulse valid_out for that one cycle and return to IDLE.
REQ-009 For an isolated input sampled at edge N (FSM IDLE, FIFO empty), valid_out SHALL be high in the cycle following edge N+12.
REQ-010 Back-to-back results SHALL be spaced exactly 12 cycles apart and SHALL be delivered in input order.
REQ-011 norm SHALL equal floor(sqrt(f)) for all f in 0..1048575, where the maximum value is 1023.
REQ-012 If the popped entry has ovf_in=1, the result SHALL be norm=10'h3FF and overflow=1; otherwise overflow=0.
REQ-013 norm and overflow SHALL hold their last values while valid_out=0.
REQ-014 A simultaneous push and pop SHALL leave the FIFO count unchanged, with the pushed entry queued behind the existing entries.

Reset
REQ-015 While reset=1, the block SHALL set norm=0, overflow=0, valid_out=0, drop=0 and busy=0, empty the FIFO, and put the FSM in IDLE.
REQ-016 Reset during CALC or DONE SHALL abandon the in-flight result, and no valid_out SHALL occur for it.
REQ-017 valid_in asserted in the reset cycle SHALL be ignored.

Structure
REQ-018 Package l2_pkg SHALL hold F_W=20, NORM_W=10, SQRT_ITERS=10, FIFO_DEPTH=4 and the FSM state enum.
REQ-019 The FIFO SHALL be a separate sub-module l2_sqrt_fifo with push, pop, full, empty and count; the square-root datapath and FSM SHALL be in l2_sqrt.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
  f=0, 1, 143, 144 isolated -> norm 0, 1, 11, 12; valid_out exactly 12 cycles after each sample; overflow=0.
  f=1048575 -> norm=1023; f=1046529 -> norm=1023; f=1046528 -> norm=1022.
  f=500 with ovf_in=1 -> norm=10'h3FF, overflow=1 on the valid_out cycle.
  6 consecutive valid_in cycles with f=16, 25, 36, 49, 64, 81 -> the 6th is dropped, drop=1; results 4, 5, 6, 7, 8 appear 12 cycles apart; busy=0 after the last result.
  Reset asserted 5 cycles into CALC with 2 entries queued -> no valid_out within 30 cycles after reset; norm=0, drop=0, busy=0.
  Random f with random valid_in gaps of at least 12 cycles, checked against a floor(sqrt) model -> no mismatches, drop stays 0.
